// File: rtl/config_stream_loader.sv
// Feeds the core-top configuration shift register: accepts words over valid/ready,
// clears the register, then shifts exactly CONFIG_LENGTH bits out MSB-first.
module config_stream_loader #(
  parameter int CONFIG_LENGTH = 2034,
  parameter int WORD_WIDTH    = 8,
  parameter int CLEAR_CYCLES  = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  config_out,
  output logic                  config_enable,
  output logic                  config_nreset,
  output logic                  busy,
  output logic                  done
);

  localparam int NWORDS    = (CONFIG_LENGTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int LAST_BITS = CONFIG_LENGTH - (NWORDS - 1) * WORD_WIDTH;
  localparam int BIT_W     = $clog2(WORD_WIDTH + 1);
  localparam int WORDS_W   = $clog2(NWORDS + 1);
  localparam int TOTAL_W   = $clog2(CONFIG_LENGTH + 1);
  localparam int CLR_W     = $clog2(CLEAR_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_t;

  state_t                state, state_next;
  logic [WORD_WIDTH-1:0] hold, hold_next;
  logic [BIT_W-1:0]      bit_cnt, bit_cnt_next;
  logic [WORDS_W-1:0]    words_left, words_left_next;
  logic [TOTAL_W-1:0]    bits_total, bits_total_next;
  logic [CLR_W-1:0]      clr_cnt, clr_cnt_next;
  logic                  bit_avail;
  logic                  xfer;

  // A word can land on the same edge that consumes the last held bit, so a
  // continuous stream has no bubble between words.
  assign word_ready = (state == SHIFT) && (words_left != '0) &&
                      ((bit_cnt == '0) || (bit_cnt == BIT_W'(1)));
  assign xfer       = word_valid && word_ready;

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_next      = state;
    hold_next       = hold;
    bit_cnt_next    = bit_cnt;
    words_left_next = words_left;
    bits_total_next = bits_total;
    clr_cnt_next    = clr_cnt;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next   = CLEAR;
          clr_cnt_next = CLR_W'(CLEAR_CYCLES);
        end
      end
      CLEAR: begin
        if (abort) begin
          state_next = IDLE;
        end else if (clr_cnt == CLR_W'(1)) begin
          state_next      = SHIFT;
          bits_total_next = TOTAL_W'(CONFIG_LENGTH);
          words_left_next = WORDS_W'(NWORDS);
          bit_cnt_next    = '0;
        end else begin
          clr_cnt_next = clr_cnt - CLR_W'(1);
        end
      end
      SHIFT: begin
        if (abort) begin
          state_next   = IDLE;
          bit_cnt_next = '0;
        end else begin
          if (bit_avail) begin
            bit_cnt_next    = bit_cnt - BIT_W'(1);
            bits_total_next = bits_total - TOTAL_W'(1);
            // The last bit stays in place so config_out holds during a gap.
            if (bit_cnt > BIT_W'(1)) hold_next = hold << 1;
            if (bits_total == TOTAL_W'(1)) state_next = DONE;
          end
          if (xfer) begin
            hold_next       = word_in;
            words_left_next = words_left - WORDS_W'(1);
            bit_cnt_next    = (words_left == WORDS_W'(1)) ? BIT_W'(LAST_BITS)
                                                          : BIT_W'(WORD_WIDTH);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      hold       <= '0;
      bit_cnt    <= '0;
      words_left <= '0;
      bits_total <= '0;
      clr_cnt    <= '0;
      bit_avail  <= 1'b0;
    end else begin
      state      <= state_next;
      hold       <= hold_next;
      bit_cnt    <= bit_cnt_next;
      words_left <= words_left_next;
      bits_total <= bits_total_next;
      clr_cnt    <= clr_cnt_next;
      bit_avail  <= (bit_cnt_next != '0);
    end
  end

  assign config_out    = hold[WORD_WIDTH-1];
  assign config_enable = bit_avail;
  // Released outside CLEAR so a loader reset never wipes the loaded configuration.
  assign config_nreset = (state != CLEAR);
  assign busy          = (state == CLEAR) || (state == SHIFT);
  assign done          = (state == DONE);

endmodule

// File: tb/tb_config_stream_loader.sv
// Directed bench: a 10-bit loader for cycle-exact timing checks and a default
// 2034-bit loader for full-stream, gap and abort scenarios.
module tb_config_stream_loader;

  localparam int BIG_LEN   = 2034;
  localparam int BIG_WORDS = 255;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       s_reset, s_start, s_abort, s_valid;
  logic [7:0] s_word;
  logic       s_ready, s_out, s_en, s_nreset, s_busy, s_done;

  logic       b_reset, b_start, b_abort, b_valid;
  logic [7:0] b_word;
  logic       b_ready, b_out, b_en, b_nreset, b_busy, b_done;

  config_stream_loader #(.CONFIG_LENGTH(10), .WORD_WIDTH(8), .CLEAR_CYCLES(2)) dut_small (
    .clock(clock), .reset(s_reset), .start(s_start), .abort(s_abort),
    .word_in(s_word), .word_valid(s_valid), .word_ready(s_ready),
    .config_out(s_out), .config_enable(s_en), .config_nreset(s_nreset),
    .busy(s_busy), .done(s_done)
  );

  config_stream_loader dut_big (
    .clock(clock), .reset(b_reset), .start(b_start), .abort(b_abort),
    .word_in(b_word), .word_valid(b_valid), .word_ready(b_ready),
    .config_out(b_out), .config_enable(b_en), .config_nreset(b_nreset),
    .busy(b_busy), .done(b_done)
  );

  int checks = 0;
  int errors = 0;

  logic [9:0]         s_sr;
  logic [BIG_LEN-1:0] b_sr;
  logic [BIG_LEN-1:0] exp_big;
  logic [7:0]         bwords [BIG_WORDS];

  int en_cnt, first_en, last_en, ready_late;
  bit done_seen, abort_hit;

  task automatic test_reset();
    #2;
    checks++;
    if ({s_ready, s_out, s_en, s_nreset, s_busy, s_done} !== 6'b000100) begin
      errors++;
      $display("FAIL reset_small: got rdy/out/en/nrst/busy/done=%b expected 000100",
               {s_ready, s_out, s_en, s_nreset, s_busy, s_done});
    end
    checks++;
    if ({b_ready, b_out, b_en, b_nreset, b_busy, b_done} !== 6'b000100) begin
      errors++;
      $display("FAIL reset_big: got rdy/out/en/nrst/busy/done=%b expected 000100",
               {b_ready, b_out, b_en, b_nreset, b_busy, b_done});
    end
    @(negedge clock);
    s_reset = 1'b0;
    b_reset = 1'b0;
  endtask

  // Cycle k is observed on the k-th falling edge after the edge that samples start.
  // Expected: CLEAR k=1..2, first word loaded k=3, bits k=4..13, DONE from k=14.
  task automatic run_small(input logic [7:0] w0, input logic [7:0] w1, input int start_k,
                           input string tag);
    logic [9:0] bits10;
    logic [4:0] exp_v, got_v;
    int widx;
    bits10 = {w0, w1[7:6]};
    widx = 0;
    s_start = 1'b1;
    s_valid = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clock);
      got_v = {s_nreset, s_en, s_ready, s_busy, s_done};
      exp_v = {!(k == 1 || k == 2), (k >= 4 && k <= 13), (k == 3 || k == 11),
               (k >= 1 && k <= 13), (k >= 14)};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL %s ctrl k=%0d: got nrst/en/rdy/busy/done=%b expected %b",
                 tag, k, got_v, exp_v);
      end
      if (k >= 4 && k <= 13) begin
        checks++;
        if (s_out !== bits10[13-k]) begin
          errors++;
          $display("FAIL %s bit k=%0d: got %b expected %b", tag, k, s_out, bits10[13-k]);
        end
      end
      if (s_en) s_sr = {s_sr[8:0], s_out};
      s_start = (k == start_k);
      s_valid = (widx < 2);
      s_word  = (widx == 0) ? w0 : w1;
      if (s_valid && s_ready) widx++;
    end
    checks++;
    if (s_sr !== 10'b1010010111) begin
      errors++;
      $display("FAIL %s shift_reg: got %b expected %b", tag, s_sr, 10'b1010010111);
    end
  endtask

  task automatic test_small_load();
    run_small(8'hA5, 8'hC0, 0, "load_a5c0");
  endtask

  task automatic test_restart_last_word();
    run_small(8'hA5, 8'hFF, 0, "restart_a5ff");
  endtask

  task automatic test_start_ignored();
    run_small(8'hA5, 8'hC0, 6, "start_in_shift");
  endtask

  task automatic reset_mid_load(input int at_k, input string tag);
    int widx;
    widx = 0;
    s_start = 1'b1;
    for (int k = 1; k <= at_k; k++) begin
      @(negedge clock);
      s_start = 1'b0;
      s_valid = (widx < 2);
      s_word  = (widx == 0) ? 8'hA5 : 8'hC0;
      if (s_valid && s_ready) widx++;
    end
    #2;
    s_reset = 1'b1;
    #1;
    checks++;
    if ({s_ready, s_out, s_en, s_nreset, s_busy, s_done} !== 6'b000100) begin
      errors++;
      $display("FAIL %s async: got rdy/out/en/nrst/busy/done=%b expected 000100",
               tag, {s_ready, s_out, s_en, s_nreset, s_busy, s_done});
    end
    @(negedge clock);
    s_reset = 1'b0;
    s_valid = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    reset_mid_load(1, "reset_in_clear");
    reset_mid_load(6, "reset_in_shift");
    run_small(8'hA5, 8'hC0, 0, "after_reset");
  endtask

  // Runs one load on the big loader; a gap withholds valid for gap_len cycles at
  // the first point word 4 could be taken; abort_bit>0 raises abort once that many
  // bits have been observed.
  task automatic run_big(input int gap_len, input int abort_bit);
    int widx, gap_rem;
    bit gap_used;
    widx = 0; gap_rem = 0; gap_used = 0;
    en_cnt = 0; first_en = -1; last_en = -1; ready_late = 0;
    done_seen = 0; abort_hit = 0;
    b_start = 1'b1;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      @(negedge clock);
      b_start = 1'b0;
      if (b_en) begin
        en_cnt++;
        b_sr = {b_sr[BIG_LEN-2:0], b_out};
        if (first_en < 0) first_en = cyc;
        last_en = cyc;
      end
      if (widx == BIG_WORDS && b_ready) ready_late++;
      if (b_done) begin
        done_seen = 1;
        break;
      end
      if (abort_bit > 0 && en_cnt == abort_bit) begin
        abort_hit = 1;
        b_abort = 1'b1;
        break;
      end
      if (gap_len > 0 && !gap_used && widx == 3 && b_ready) begin
        gap_used = 1;
        gap_rem = gap_len;
      end
      if (gap_rem > 0) begin
        b_valid = 1'b0;
        gap_rem--;
      end else begin
        b_valid = (widx < BIG_WORDS);
        b_word  = (widx < BIG_WORDS) ? bwords[widx] : 8'h00;
      end
      if (b_valid && b_ready) widx++;
    end
  endtask

  task automatic check_full_load(input string tag, input int exp_gap);
    checks++;
    if (done_seen !== 1'b1) begin
      errors++;
      $display("FAIL %s done: not reached within cycle budget, expected done=1", tag);
    end
    checks++;
    if (en_cnt !== BIG_LEN) begin
      errors++;
      $display("FAIL %s enable_count: got %0d expected %0d", tag, en_cnt, BIG_LEN);
    end
    checks++;
    if (last_en - first_en + 1 - en_cnt !== exp_gap) begin
      errors++;
      $display("FAIL %s idle_cycles: got %0d expected %0d", tag,
               last_en - first_en + 1 - en_cnt, exp_gap);
    end
    checks++;
    if (ready_late !== 0) begin
      errors++;
      $display("FAIL %s ready_after_last_word: got %0d cycles expected 0", tag, ready_late);
    end
    checks++;
    if (b_sr !== exp_big) begin
      errors++;
      $display("FAIL %s shift_reg: got %h expected %h", tag, b_sr[63:0], exp_big[63:0]);
    end
    checks++;
    if ({b_en, b_ready, b_busy} !== 3'b000) begin
      errors++;
      $display("FAIL %s done_outputs: got en/rdy/busy=%b expected 000", tag,
               {b_en, b_ready, b_busy});
    end
  endtask

  task automatic test_back_to_back();
    run_big(0, 0);
    check_full_load("back_to_back", 0);
  endtask

  task automatic test_backpressure_gap();
    run_big(5, 0);
    check_full_load("gap5", 5);
  endtask

  task automatic test_abort();
    run_big(0, 700);
    checks++;
    if (abort_hit !== 1'b1 || en_cnt !== 700) begin
      errors++;
      $display("FAIL abort_reach: got hit=%0d bits=%0d expected hit=1 bits=700",
               abort_hit, en_cnt);
    end
    @(negedge clock);
    b_abort = 1'b0;
    b_valid = 1'b0;
    checks++;
    if ({b_busy, b_done, b_en, b_ready, b_nreset} !== 5'b00001) begin
      errors++;
      $display("FAIL abort_state: got busy/done/en/rdy/nrst=%b expected 00001",
               {b_busy, b_done, b_en, b_ready, b_nreset});
    end
    run_big(0, 0);
    check_full_load("after_abort", 0);
  endtask

  initial begin
    logic [7:0] w;
    s_reset = 1'b1; s_start = 1'b0; s_abort = 1'b0; s_valid = 1'b0; s_word = 8'h00;
    b_reset = 1'b1; b_start = 1'b0; b_abort = 1'b0; b_valid = 1'b0; b_word = 8'h00;
    s_sr = '0;
    b_sr = '0;
    for (int i = 0; i < BIG_WORDS; i++) bwords[i] = 8'((i * 73 + 29) ^ (i * i));
    for (int j = 0; j < BIG_LEN; j++) begin
      w = bwords[j / 8];
      exp_big[BIG_LEN - 1 - j] = w[7 - (j % 8)];
    end

    test_reset();
    test_small_load();
    test_restart_last_word();
    test_start_ignored();
    test_reset_mid_load();
    test_back_to_back();
    test_backpressure_gap();
    test_abort();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
